pipeline_stall_ctrl: RTL and testbench
======================================

# pipeline_stall_ctrl

Consumer of the hazard-detection outputs: turns load-use, branch-operand and redirect requests into per-cycle pipeline-register controls (PC write, IF/ID write/flush, ID/EX bubble, PC select). Sits between hazard detection and the IF, ID and ID/EX stage registers of the 5-stage MIPS32 core. It also keeps saturating stall and flush counters and a consecutive-stall watchdog.

## Interface
Parameters:
- CNT_W, 32: width of the stall and flush event counters.
- MAX_STALL, 15: consecutive stall cycles that trip the watchdog (range 1 to 255).
- FLUSH_DEPTH, 1: IF/ID flush cycles per redirect (range 1 to 3).

Ports:
- clk, input, 1: the single clock; all state updates on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- ld_has_hazard, input, 1: load-use dependency between ID and EX.
- branch_hold, input, 1: branch in ID depends on the instruction in EX.
- branch_has_hazard, input, 1: taken branch or jump resolved in ID.
- pc_write, output, 1: PC register enable.
- ifid_write, output, 1: IF/ID register enable.
- ifid_flush, output, 1: clear IF/ID to NOP on the next edge.
- idex_bubble, output, 1: load a NOP into ID/EX on the next edge.
- pc_sel, output, 1: 1 selects the branch/jump target as next PC; 0 selects PC+4.
- stall_count, output, CNT_W: number of stall cycles, saturating.
- flush_count, output, CNT_W: number of redirect events, saturating.
- stall_timeout, output, 1: sticky watchdog flag.

## Operation
- stall_req = ld_has_hazard | branch_hold.
- Stall has priority over redirect. When stall_req=1, branch_has_hazard is ignored because branch operands are not yet valid.
- During a stall cycle, all of the following hold:
  - pc_write=0, ifid_write=0, idex_bubble=1.
  - ifid_flush=0, pc_sel=0.
- During a redirect cycle (stall_req=0, branch_has_hazard=1):
  - pc_sel=1, pc_write=1, ifid_flush=1, idex_bubble=0.
  - flush_count increments.
  - The FSM enters FLUSH if FLUSH_DEPTH>1.
- Normal cycle: pc_write=1, ifid_write=1, all other controls 0.
- The FSM has three states:
  - RUN: RUN to STALL on stall_req; RUN to FLUSH on a redirect when FLUSH_DEPTH>1; otherwise stays in RUN.
  - STALL: STALL to RUN when stall_req drops. Outputs in the release cycle follow the normal/redirect rules above.
  - FLUSH: ifid_flush=1 and pc_sel=0 for FLUSH_DEPTH-1 further cycles, counted by a 2-bit down-counter, then return to RUN.
  - A stall_req arriving during FLUSH takes priority: go to STALL and drop the remaining flush cycles. Those cycles are not needed, because IF/ID is already a NOP.
  - A new redirect during FLUSH reloads the flush counter and increments flush_count.
- consec counter (8-bit):
  - Increments on each stall cycle; clears on any non-stall cycle.
  - When consec reaches MAX_STALL, stall_timeout sets and holds until reset.
  - consec then saturates at MAX_STALL.
  - Pipeline controls are unaffected by the watchdog.
- stall_count and flush_count saturate at all-ones and never wrap.

## Timing
- All control outputs are combinational from the inputs and the current state, so they act in the same cycle the request is seen. This zero-cycle control latency is mandatory for a load-use stall.
- Counters, consec, the flush counter, the FSM state and stall_timeout update on the rising clk edge. They are visible one cycle after the triggering cycle.
- Load-use produces exactly one stall cycle. A branch_hold following a load produces back-to-back stall cycles, and each cycle counts.
- Reset state when rst_n=0 at an edge:
  - FSM = RUN; all counters, consec and stall_timeout = 0.
  - While rst_n=0, outputs are forced to pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, pc_sel=0.
- Reset mid-stall or mid-flush abandons the operation with no residual flush.

## Structure
- A shared package pipe_ctrl_pkg holds:
  - the state enum: RUN, STALL, FLUSH;
  - the control-bundle struct: pc_write, ifid_write, ifid_flush, idex_bubble, pc_sel;
  - the NOP-encoding constant, shared with the ID/EX register.
- One sub-module, sat_counter (parameter W, inputs inc and clear, saturating). It is instanced for stall_count and flush_count, and with W=8 for consec.

## Test plan
- Single ld_has_hazard pulse for 1 cycle → that cycle: pc_write=0, ifid_write=0, idex_bubble=1. Next cycle: normal controls, and stall_count=1.
- branch_hold=1 for 3 cycles, then branch_has_hazard=1 for 1 cycle:
  - → 3 stall cycles, then one cycle with pc_sel=1 and ifid_flush=1.
  - → stall_count=3, flush_count=1.
- branch_hold=1 and branch_has_hazard=1 together for 2 cycles → stall only: pc_sel=0 and ifid_flush=0 both cycles; flush_count stays 0.
- FLUSH_DEPTH=3 with a redirect at cycle 10:
  - → ifid_flush=1 in cycles 10–12; pc_sel=1 only in cycle 10.
  - A stall_req injected at cycle 11 instead → ifid_flush=0 from cycle 11 and the FSM goes to STALL.
- MAX_STALL=15 with stall_req held 20 cycles → stall_timeout rises after the 15th stall cycle, then stays 1 after stall_req drops; stall_count=20.
- stall_count preloaded near saturation (CNT_W=4) with 20 stall cycles → stall_count holds at 15. Asserting rst_n=0 mid-stall → next cycle all counters 0, state RUN, normal controls.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the pipeline stall controller: FSM states, the per-cycle
// control bundle, and the NOP instruction word also used by the ID/EX register.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic pc_sel;
  } ctrl_t;

  // sll $0,$0,0 -- the canonical MIPS32 NOP
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam ctrl_t CTRL_NORMAL   = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                      idex_bubble: 1'b0, pc_sel: 1'b0};
  localparam ctrl_t CTRL_STALL    = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                      idex_bubble: 1'b1, pc_sel: 1'b0};
  localparam ctrl_t CTRL_REDIRECT = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                      idex_bubble: 1'b0, pc_sel: 1'b1};
  localparam ctrl_t CTRL_FLUSH    = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                      idex_bubble: 1'b0, pc_sel: 1'b0};

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard-request inputs and stage-register controls/statistics of the stall controller.
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             ld_has_hazard;
  logic             branch_hold;
  logic             branch_has_hazard;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             pc_sel;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic             stall_timeout;

  modport master (
    output ld_has_hazard, branch_hold, branch_has_hazard,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, pc_sel,
    input  stall_count, flush_count, stall_timeout
  );

  modport slave (
    input  ld_has_hazard, branch_hold, branch_has_hazard,
    output pc_write, ifid_write, ifid_flush, idex_bubble, pc_sel,
    output stall_count, flush_count, stall_timeout
  );
endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones; clear wins over inc.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Turns hazard requests into same-cycle pipeline-register controls; keeps
// saturating stall/redirect statistics and a sticky consecutive-stall watchdog.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MAX_STALL   = 15,
  parameter int FLUSH_DEPTH = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  pipeline_stall_ctrl_if.slave bus
);
  localparam bit         USE_FLUSH    = (FLUSH_DEPTH > 1);
  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_DEPTH - 1);
  localparam logic [7:0] CONSEC_MAX   = 8'(MAX_STALL);
  localparam logic [7:0] CONSEC_LAST  = 8'(MAX_STALL - 1);

  logic             w_stall_req;
  logic             w_redirect;
  ctrl_t            w_ctrl;
  logic [7:0]       w_consec;
  logic [CNT_W-1:0] w_stall_count;
  logic [CNT_W-1:0] w_flush_count;
  state_t           r_state;
  logic [1:0]       r_flush_left;
  logic             r_timeout;

  // Branch operands are not valid while stalled, so a stall masks the redirect.
  assign w_stall_req = bus.ld_has_hazard | bus.branch_hold;
  assign w_redirect  = ~w_stall_req & bus.branch_has_hazard;

  always_comb begin
    w_ctrl = CTRL_NORMAL;
    if (!rst_n) begin
      w_ctrl = CTRL_NORMAL;
    end else if (w_stall_req) begin
      w_ctrl = CTRL_STALL;
    end else if (w_redirect) begin
      w_ctrl = CTRL_REDIRECT;
    end else if (r_state == FLUSH) begin
      w_ctrl = CTRL_FLUSH;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_flush_left <= 2'd0;
    end else if (w_stall_req) begin
      // IF/ID already holds a NOP, so leftover flush cycles are dropped.
      r_state      <= STALL;
      r_flush_left <= 2'd0;
    end else if (w_redirect && USE_FLUSH) begin
      r_state      <= FLUSH;
      r_flush_left <= FLUSH_RELOAD;
    end else if ((r_state == FLUSH) && (r_flush_left > 2'd1)) begin
      r_state      <= FLUSH;
      r_flush_left <= r_flush_left - 2'd1;
    end else begin
      r_state      <= RUN;
      r_flush_left <= 2'd0;
    end
  end

  // Set on the edge where consec reaches MAX_STALL so both become visible together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_timeout <= 1'b0;
    end else if (w_stall_req && (w_consec == CONSEC_LAST)) begin
      r_timeout <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall_req),
    .clear (1'b0),
    .count (w_stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_redirect),
    .clear (1'b0),
    .count (w_flush_count)
  );

  sat_counter #(.W(8)) u_consec (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall_req && (w_consec != CONSEC_MAX)),
    .clear (~w_stall_req),
    .count (w_consec)
  );

  assign bus.pc_write      = w_ctrl.pc_write;
  assign bus.ifid_write    = w_ctrl.ifid_write;
  assign bus.ifid_flush    = w_ctrl.ifid_flush;
  assign bus.idex_bubble   = w_ctrl.idex_bubble;
  assign bus.pc_sel        = w_ctrl.pc_sel;
  assign bus.stall_count   = w_stall_count;
  assign bus.flush_count   = w_flush_count;
  assign bus.stall_timeout = r_timeout;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Drives three differently parameterised controllers with one stimulus stream
// and checks every cycle against a cycle-level behavioural model.
module tb_pipeline_stall_ctrl;
  localparam int N = 3;

  function automatic int cfg_w(input int i);
    case (i) 0: return 32; 1: return 16; default: return 4; endcase
  endfunction
  function automatic int cfg_max(input int i);
    case (i) 0: return 15; 1: return 4; default: return 1; endcase
  endfunction
  function automatic int cfg_fd(input int i);
    case (i) 0: return 1; 1: return 3; default: return 2; endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, ld, bh, bhh;

  pipeline_stall_ctrl_if #(.CNT_W(32)) if0 ();
  pipeline_stall_ctrl_if #(.CNT_W(16)) if1 ();
  pipeline_stall_ctrl_if #(.CNT_W(4))  if2 ();

  assign if0.ld_has_hazard = ld; assign if0.branch_hold = bh; assign if0.branch_has_hazard = bhh;
  assign if1.ld_has_hazard = ld; assign if1.branch_hold = bh; assign if1.branch_has_hazard = bhh;
  assign if2.ld_has_hazard = ld; assign if2.branch_hold = bh; assign if2.branch_has_hazard = bhh;

  pipeline_stall_ctrl #(.CNT_W(32), .MAX_STALL(15), .FLUSH_DEPTH(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  pipeline_stall_ctrl #(.CNT_W(16), .MAX_STALL(4),  .FLUSH_DEPTH(3)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  pipeline_stall_ctrl #(.CNT_W(4),  .MAX_STALL(1),  .FLUSH_DEPTH(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  // Control bit order: {pc_write, ifid_write, ifid_flush, idex_bubble, pc_sel}
  logic [4:0]  obs_ctl [N];
  logic [31:0] obs_sc  [N];
  logic [31:0] obs_fc  [N];
  logic        obs_to  [N];

  assign obs_ctl[0] = {if0.pc_write, if0.ifid_write, if0.ifid_flush, if0.idex_bubble, if0.pc_sel};
  assign obs_ctl[1] = {if1.pc_write, if1.ifid_write, if1.ifid_flush, if1.idex_bubble, if1.pc_sel};
  assign obs_ctl[2] = {if2.pc_write, if2.ifid_write, if2.ifid_flush, if2.idex_bubble, if2.pc_sel};
  assign obs_sc[0] = if0.stall_count;
  assign obs_sc[1] = 32'(if1.stall_count);
  assign obs_sc[2] = 32'(if2.stall_count);
  assign obs_fc[0] = if0.flush_count;
  assign obs_fc[1] = 32'(if1.flush_count);
  assign obs_fc[2] = 32'(if2.flush_count);
  assign obs_to[0] = if0.stall_timeout;
  assign obs_to[1] = if1.stall_timeout;
  assign obs_to[2] = if2.stall_timeout;

  longint m_sc [N];
  longint m_fc [N];
  int     m_left [N];
  int     m_consec [N];
  bit     m_to [N];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;

  task automatic step(input logic r, input logic l, input logic b, input logic h);
    logic [4:0] exp_ctl, mask;
    longint     maxv;
    @(negedge clk);
    rst_n = r; ld = l; bh = b; bhh = h;
    #2;
    for (int i = 0; i < N; i++) begin
      if (!r)               begin exp_ctl = 5'b11000; mask = 5'b11111; end
      else if (l | b)       begin exp_ctl = 5'b00010; mask = 5'b11111; end
      else if (h)           begin exp_ctl = 5'b10101; mask = 5'b10111; end
      else if (m_left[i] > 0) begin exp_ctl = 5'b00100; mask = 5'b00111; end
      else                  begin exp_ctl = 5'b11000; mask = 5'b11111; end

      checks++;
      assert ((obs_ctl[i] & mask) === exp_ctl) else begin
        errors++;
        $error("FAIL ctl u%0d cyc %0d: got %b need %b (mask %b)", i, cyc, obs_ctl[i], exp_ctl, mask);
      end
      checks++;
      assert (obs_sc[i] === 32'(m_sc[i])) else begin
        errors++;
        $error("FAIL stall_count u%0d cyc %0d: got %0d need %0d", i, cyc, obs_sc[i], m_sc[i]);
      end
      checks++;
      assert (obs_fc[i] === 32'(m_fc[i])) else begin
        errors++;
        $error("FAIL flush_count u%0d cyc %0d: got %0d need %0d", i, cyc, obs_fc[i], m_fc[i]);
      end
      checks++;
      assert (obs_to[i] === m_to[i]) else begin
        errors++;
        $error("FAIL stall_timeout u%0d cyc %0d: got %b need %b", i, cyc, obs_to[i], m_to[i]);
      end
    end
    $display("cyc %0d rst_n=%b ld=%b bh=%b br=%b ctl=%b/%b/%b sc=%0d/%0d/%0d fc=%0d/%0d/%0d to=%b%b%b",
             cyc, r, l, b, h, obs_ctl[0], obs_ctl[1], obs_ctl[2], obs_sc[0], obs_sc[1], obs_sc[2],
             obs_fc[0], obs_fc[1], obs_fc[2], obs_to[0], obs_to[1], obs_to[2]);

    // Model state advances with the coming rising edge.
    for (int i = 0; i < N; i++) begin
      maxv = longint'((64'd1 << cfg_w(i)) - 64'd1);
      if (!r) begin
        m_sc[i] = 0; m_fc[i] = 0; m_left[i] = 0; m_consec[i] = 0; m_to[i] = 0;
      end else if (l | b) begin
        if (m_sc[i] < maxv) m_sc[i]++;
        if (m_consec[i] < cfg_max(i)) m_consec[i]++;
        if (m_consec[i] == cfg_max(i)) m_to[i] = 1;
        m_left[i] = 0;
      end else begin
        m_consec[i] = 0;
        if (h) begin
          if (m_fc[i] < maxv) m_fc[i]++;
          m_left[i] = cfg_fd(i) - 1;
        end else if (m_left[i] > 0) begin
          m_left[i]--;
        end
      end
    end
    cyc++;
  endtask

  task automatic repeat_step(input int n, input logic l, input logic b, input logic h);
    for (int k = 0; k < n; k++) step(1'b1, l, b, h);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_sc[i] = 0; m_fc[i] = 0; m_left[i] = 0; m_consec[i] = 0; m_to[i] = 0;
    end
    rst_n = 1'b0; ld = 1'b0; bh = 1'b0; bhh = 1'b0;
    repeat (2) @(posedge clk);

    // Requests while in reset must not reach the controls.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    repeat_step(2, 1'b0, 1'b0, 1'b0);

    // Single load-use stall.
    repeat_step(1, 1'b1, 1'b0, 1'b0);
    repeat_step(1, 1'b0, 1'b0, 1'b0);

    // Branch operand hold for 3 cycles, then redirect.
    repeat_step(3, 1'b0, 1'b1, 1'b0);
    repeat_step(1, 1'b0, 1'b0, 1'b1);
    repeat_step(3, 1'b0, 1'b0, 1'b0);

    // Hold and redirect together: stall wins.
    repeat_step(2, 1'b0, 1'b1, 1'b1);
    repeat_step(2, 1'b0, 1'b0, 1'b0);

    // Redirect followed by full flush tail.
    repeat_step(1, 1'b0, 1'b0, 1'b1);
    repeat_step(4, 1'b0, 1'b0, 1'b0);

    // Stall cuts a flush tail short.
    repeat_step(1, 1'b0, 1'b0, 1'b1);
    repeat_step(1, 1'b1, 1'b0, 1'b0);
    repeat_step(3, 1'b0, 1'b0, 1'b0);

    // Redirect during flush reloads the tail.
    repeat_step(1, 1'b0, 1'b0, 1'b1);
    repeat_step(1, 1'b0, 1'b0, 1'b0);
    repeat_step(1, 1'b0, 1'b0, 1'b1);
    repeat_step(4, 1'b0, 1'b0, 1'b0);

    // Long stall trips the watchdogs and saturates the narrow counter.
    repeat_step(20, 1'b0, 1'b1, 1'b0);
    repeat_step(3, 1'b0, 1'b0, 1'b0);

    // Random traffic with occasional reset.
    for (int k = 0; k < 150; k++) begin
      step(($urandom_range(49) != 0), ($urandom_range(4) == 0),
           ($urandom_range(5) == 0), ($urandom_range(3) == 0));
    end

    // Reset in the middle of a stall, then in the middle of a flush.
    repeat_step(5, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat_step(2, 1'b0, 1'b0, 1'b0);
    repeat_step(1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat_step(3, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
